bk_mac_accum_seq: RTL and testbench
===================================

// Module: bk_mac_accum_seq
// PURPOSE
//  Sequencer that performs 64-bit unsigned accumulation of multiplier products using one external
//  32-bit Brent-Kung adder (33-bit sum incl. carry-out), time-shared over low then high halves.
//  Sits between the Wallace multiplier output stream and the MAC result consumer; owns the accumulator.
//  Accumulates num_terms products per run, then presents the 64-bit total.
// PARAMETERS
//  CNT_W   8   width of num_terms / term counter (max 2**CNT_W-1 terms per run)
// PORTS
//  clk        in   1      single clock, all state on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      begin a run; sampled only in IDLE
//  num_terms  in   CNT_W  products to accumulate; sampled with start
//  in_valid   in   1      product available
//  in_data    in   64     product from multiplier
//  in_ready   out  1      sequencer accepts product this cycle
//  add_a      out  32     adder operand A
//  add_b      out  32     adder operand B
//  add_cin    out  1      adder carry-in
//  add_sum    in   33     adder result {cout,sum[31:0]}, combinational from add_a/add_b/add_cin
//  acc_out    out  64     accumulated total; valid when out_valid
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  busy       out  1      high in any state except IDLE
//  overflow   out  1      sticky: carry out of bit 63 during current/last run
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; acc, op, carry_q, count, overflow cleared; all outputs 0.
//  Reset mid-run abandons the run; no partial result is ever presented.
//  FSM states: IDLE, WAIT_IN, ADD_LO, ADD_HI, DONE.
//  IDLE: busy=0. start&&num_terms!=0 -> acc=0, overflow=0, count=num_terms, ->WAIT_IN.
//        start&&num_terms==0 -> acc=0, overflow=0, ->DONE (out_valid next cycle).
//  WAIT_IN: in_ready=1. in_valid -> op<=in_data, ->ADD_LO. No in_valid: stay.
//  ADD_LO: add_a=acc[31:0], add_b=op[31:0], add_cin=0; acc[31:0]<=add_sum[31:0];
//          carry_q<=add_sum[32]; ->ADD_HI.
//  ADD_HI: add_a=acc[63:32], add_b=op[63:32], add_cin=carry_q; acc[63:32]<=add_sum[31:0];
//          overflow<=overflow|add_sum[32]; count<=count-1; count==1 -> DONE, else ->WAIT_IN.
//  DONE: out_valid=1, acc_out=acc held stable; out_ready -> IDLE (out_valid low next cycle).
//  add_a/add_b/add_cin are registered-state decodes, driven 0 outside ADD_LO/ADD_HI.
//  in_ready=1 only in WAIT_IN; out_valid=1 only in DONE; acc_out=0 unless in DONE.
//  Throughput: 3 cycles per term min (accept, LO, HI); result out_valid 1 cycle after last HI.
//  start outside IDLE ignored (incl. start coincident with out_ready in DONE: returns to IDLE only).
//  Arithmetic: unsigned modulo 2**64; overflow does not stop the run.
//  Timing: clock period must exceed adder gate-delay path; benches use >=20 ns period.
// TESTING
//  1) start, num_terms=3; products 1,2,3 back-to-back -> acc_out=64'd6, overflow=0,
//     out_valid 10 cycles after start edge.
//  2) num_terms=2; 64'h0000_0000_FFFF_FFFF then 64'h1 -> acc_out=64'h0000_0001_0000_0000
//     (carry_q=1 into HI half).
//  3) num_terms=2; 64'hFFFF_FFFF_FFFF_FFFF then 64'h2 -> acc_out=64'h1, overflow=1;
//     next run with 5+7 -> acc_out=12, overflow=0.
//  4) num_terms=0 -> out_valid=1 next cycle, acc_out=0, in_ready never asserted.
//  5) in_valid gaps of 4 cycles between terms; out_ready low 5 cycles in DONE, start pulsed
//     meanwhile -> acc_out stable, start ignored, single handshake on out_ready.
//  6) rst_n low during ADD_HI of term 2 of 4 -> all outputs 0 immediately; new run 9+1
//     gives acc_out=10.

Source files
------------

// File: rtl/bk_mac_accum_seq.sv
// ============================================================================
//  bk_mac_accum_seq
//  64-bit unsigned product accumulator, time-sharing one 32-bit external adder
//  Revision: 1.0
// ============================================================================
`default_nettype none

module bk_mac_accum_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_terms_i,
  input  logic             in_valid_i,
  input  logic [63:0]      in_data_i,
  output logic             in_ready_o,
  output logic [31:0]      add_a_o,
  output logic [31:0]      add_b_o,
  output logic             add_cin_o,
  input  logic [32:0]      add_sum_i,
  output logic [63:0]      acc_out_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             overflow_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_IN = 3'd1,
    ADD_LO  = 3'd2,
    ADD_HI  = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;

  state_e           state_q, state_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      op_q, op_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      op_q       <= '0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      carry_q    <= carry_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    carry_d     = carry_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    in_ready_o  = 1'b0;
    add_a_o     = '0;
    add_b_o     = '0;
    add_cin_o   = 1'b0;
    out_valid_o = 1'b0;
    acc_out_o   = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d      = '0;
          overflow_d = 1'b0;
          if (num_terms_i != c_CNT_ZERO) begin
            count_d = num_terms_i;
            state_d = WAIT_IN;
          end else begin
            state_d = DONE;
          end
        end
      end

      WAIT_IN: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          op_d    = in_data_i;
          state_d = ADD_LO;
        end
      end

      ADD_LO: begin
        add_a_o     = acc_q[31:0];
        add_b_o     = op_q[31:0];
        acc_d[31:0] = add_sum_i[31:0];
        carry_d     = add_sum_i[32];
        state_d     = ADD_HI;
      end

      // Carry out of the upper half is the carry out of bit 63 of the whole sum.
      ADD_HI: begin
        add_a_o      = acc_q[63:32];
        add_b_o      = op_q[63:32];
        add_cin_o    = carry_q;
        acc_d[63:32] = add_sum_i[31:0];
        overflow_d   = overflow_q | add_sum_i[32];
        count_d      = count_q - c_CNT_ONE;
        state_d      = (count_q == c_CNT_ONE) ? DONE : WAIT_IN;
      end

      DONE: begin
        out_valid_o = 1'b1;
        acc_out_o   = acc_q;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_bk_mac_accum_seq.sv
// Randomised and directed bench for bk_mac_accum_seq with a behavioural 33-bit adder
// and an exact-arithmetic reference for the accumulated total.
`default_nettype none

module tb_bk_mac_accum_seq;

  localparam int CNT_W = 8;
  localparam int BOUND = 60;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic [CNT_W-1:0] num_terms_i;
  logic             in_valid_i;
  logic [63:0]      in_data_i;
  logic             in_ready_o;
  logic [31:0]      add_a_o;
  logic [31:0]      add_b_o;
  logic             add_cin_o;
  logic [32:0]      add_sum_i;
  logic [63:0]      acc_out_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             busy_o;
  logic             overflow_o;

  int checks;
  int errors;
  int cyc;
  logic [63:0] prods[$];

  bk_mac_accum_seq #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .num_terms_i (num_terms_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .add_a_o     (add_a_o),
    .add_b_o     (add_b_o),
    .add_cin_o   (add_cin_o),
    .add_sum_i   (add_sum_i),
    .acc_out_o   (acc_out_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o)
  );

  // The external Brent-Kung adder, modelled behaviourally.
  assign add_sum_i = {1'b0, add_a_o} + {1'b0, add_b_o} + {32'd0, add_cin_o};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exact sum of the queued products; bits above 63 mean the run wrapped.
  task automatic ref_model(output logic [63:0] sum, output logic ovf);
    logic [71:0] exact;
    exact = '0;
    foreach (prods[i]) exact = exact + {8'd0, prods[i]};
    sum = exact[63:0];
    ovf = |exact[71:64];
  endtask

  task automatic issue_start(input int n, output int start_cyc);
    start_i     = 1'b1;
    num_terms_i = CNT_W'(n);
    @(posedge clk);
    #1;
    start_cyc   = cyc;
    start_i     = 1'b0;
    num_terms_i = CNT_W'($urandom);
  endtask

  task automatic feed(input logic [63:0] d, output bit ok);
    int k;
    in_valid_i = 1'b1;
    in_data_i  = d;
    k = 0;
    while (!in_ready_o && k < BOUND) begin
      tick();
      k++;
    end
    ok = (k < BOUND);
    if (ok) tick();
    in_valid_i = 1'b0;
    in_data_i  = {$urandom, $urandom};
  endtask

  task automatic wait_out(output bit ok);
    int k;
    k = 0;
    while (!out_valid_o && k < BOUND) begin
      tick();
      k++;
    end
    ok = (k < BOUND);
  endtask

  // Feeds every queued product with 'gap' idle cycles after each, returns at out_valid.
  task automatic drive_run(input int gap, output int lat, output bit ok);
    int s;
    bit fok;
    ok = 1'b1;
    issue_start(prods.size(), s);
    foreach (prods[i]) begin
      feed(prods[i], fok);
      if (!fok) ok = 1'b0;
      repeat (gap) tick();
    end
    wait_out(fok);
    if (!fok) ok = 1'b0;
    lat = cyc - s;
  endtask

  task automatic release_result();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #25;
    checks++;
    if ({in_ready_o, add_a_o, add_b_o, add_cin_o, acc_out_o, out_valid_o, busy_o, overflow_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: observed in_ready=%b add_a=%h add_b=%h cin=%b acc=%h ov=%b busy=%b ovf=%b expected all 0",
               in_ready_o, add_a_o, add_b_o, add_cin_o, acc_out_o, out_valid_o, busy_o, overflow_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: observed busy=%b in_ready=%b expected 0 0", busy_o, in_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit ok;
    logic [63:0] es;
    logic eo;
    prods = '{64'd1, 64'd2, 64'd3};
    ref_model(es, eo);
    drive_run(0, lat, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout: observed timeout expected result");
    end
    // Start edge counts as the first of ten edges before out_valid is seen.
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL b2b_latency: observed %0d edges after start edge expected 9", lat);
    end
    checks++;
    if (acc_out_o !== es || overflow_o !== eo) begin
      errors++;
      $display("FAIL b2b_sum: observed %h/%b expected %h/%b", acc_out_o, overflow_o, es, eo);
    end
    release_result();
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_release: observed ov=%b busy=%b expected 0 0", out_valid_o, busy_o);
    end
  endtask

  task automatic test_carry_half();
    int lat;
    bit ok;
    prods = '{64'h0000_0000_FFFF_FFFF, 64'h1};
    drive_run(0, lat, ok);
    checks++;
    if (!ok || acc_out_o !== 64'h0000_0001_0000_0000 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL carry_half: observed ok=%b acc=%h ovf=%b expected 1 0000000100000000 0", ok, acc_out_o, overflow_o);
    end
    release_result();
  endtask

  task automatic test_overflow();
    int lat;
    int s;
    bit ok;
    prods = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h2};
    drive_run(1, lat, ok);
    checks++;
    if (!ok || acc_out_o !== 64'h1 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_run: observed ok=%b acc=%h ovf=%b expected 1 1 1", ok, acc_out_o, overflow_o);
    end
    release_result();
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: observed %b expected 1", overflow_o);
    end
    issue_start(2, s);
    checks++;
    if (overflow_o !== 1'b0 || acc_out_o !== 64'd0) begin
      errors++;
      $display("FAIL overflow_clear: observed ovf=%b acc=%h expected 0 0", overflow_o, acc_out_o);
    end
    begin
      bit fok;
      feed(64'd5, fok);
      feed(64'd7, fok);
      wait_out(ok);
      ok = ok & fok;
    end
    checks++;
    if (!ok || acc_out_o !== 64'd12 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL overflow_next_run: observed ok=%b acc=%h ovf=%b expected 1 c 0", ok, acc_out_o, overflow_o);
    end
    release_result();
  endtask

  task automatic test_zero_terms();
    int s;
    bit saw_ready;
    saw_ready = in_ready_o;
    issue_start(0, s);
    saw_ready |= in_ready_o;
    checks++;
    if (out_valid_o !== 1'b1 || acc_out_o !== 64'd0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL zero_terms: observed ov=%b acc=%h busy=%b expected 1 0 1", out_valid_o, acc_out_o, busy_o);
    end
    release_result();
    saw_ready |= in_ready_o;
    checks++;
    if (saw_ready !== 1'b0 || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_in_ready: observed in_ready_seen=%b ov=%b expected 0 0", saw_ready, out_valid_o);
    end
  endtask

  task automatic test_gaps_and_hold();
    int lat;
    bit ok;
    bit stable;
    int vcount;
    logic [63:0] es;
    logic eo;
    logic [63:0] first;
    prods = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h0000_0001_FFFF_FFFF};
    ref_model(es, eo);
    drive_run(4, lat, ok);
    first  = acc_out_o;
    stable = ok;
    for (int j = 0; j < 5; j++) begin
      start_i     = (j == 2);
      num_terms_i = CNT_W'(3);
      tick();
      if (acc_out_o !== first || out_valid_o !== 1'b1 || in_ready_o !== 1'b0) stable = 1'b0;
    end
    start_i = 1'b0;
    checks++;
    if (!stable || first !== es || overflow_o !== eo) begin
      errors++;
      $display("FAIL gaps_hold: observed stable=%b acc=%h ovf=%b expected 1 %h %b", stable, first, overflow_o, es, eo);
    end
    // Start coincident with out_ready must only return to IDLE.
    start_i     = 1'b1;
    out_ready_i = 1'b1;
    tick();
    start_i     = 1'b0;
    out_ready_i = 1'b0;
    vcount = 0;
    for (int j = 0; j < 3; j++) begin
      if (out_valid_o || busy_o || in_ready_o) vcount++;
      tick();
    end
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL gaps_single_handshake: observed %0d busy cycles after handshake expected 0", vcount);
    end
  endtask

  task automatic test_reset_mid_run();
    int s;
    bit ok;
    bit fok;
    issue_start(4, s);
    feed(64'h0000_0003_8000_0000, ok);
    feed(64'h0000_0004_8000_0000, fok);
    ok = ok & fok;
    tick();
    checks++;
    if (!ok || add_a_o !== 32'd3 || add_b_o !== 32'd4 || add_cin_o !== 1'b1) begin
      errors++;
      $display("FAIL midrun_add_hi: observed ok=%b a=%h b=%h cin=%b expected 1 3 4 1", ok, add_a_o, add_b_o, add_cin_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready_o, add_a_o, add_b_o, add_cin_o, acc_out_o, out_valid_o, busy_o, overflow_o} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: observed in_ready=%b a=%h b=%h cin=%b acc=%h ov=%b busy=%b ovf=%b expected all 0",
               in_ready_o, add_a_o, add_b_o, add_cin_o, acc_out_o, out_valid_o, busy_o, overflow_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    prods = '{64'd9, 64'd1};
    begin
      int lat;
      drive_run(0, lat, ok);
    end
    checks++;
    if (!ok || acc_out_o !== 64'd10 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL midrun_new_run: observed ok=%b acc=%h ovf=%b expected 1 a 0", ok, acc_out_o, overflow_o);
    end
    release_result();
  endtask

  task automatic test_random();
    int lat;
    bit ok;
    bit idle_ok;
    logic [63:0] es;
    logic eo;
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 6);
      prods = {};
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0:       prods.push_back({$urandom, $urandom});
          1:       prods.push_back({32'hFFFF_FFFF, $urandom});
          2:       prods.push_back({32'd0, $urandom});
          default: prods.push_back(64'(~($urandom_range(0, 3))));
        endcase
      end
      ref_model(es, eo);
      drive_run($urandom_range(0, 2), lat, ok);
      checks++;
      if (!ok || acc_out_o !== es || overflow_o !== eo) begin
        errors++;
        $display("FAIL random_run%0d: observed ok=%b acc=%h ovf=%b expected 1 %h %b", r, ok, acc_out_o, overflow_o, es, eo);
      end
      repeat ($urandom_range(0, 3)) tick();
      release_result();
      idle_ok = (out_valid_o === 1'b0) && (busy_o === 1'b0) && (add_a_o === '0) && (add_b_o === '0) && (acc_out_o === '0);
      checks++;
      if (!idle_ok) begin
        errors++;
        $display("FAIL random_idle%0d: observed ov=%b busy=%b a=%h b=%h acc=%h expected all 0", r, out_valid_o, busy_o, add_a_o, add_b_o, acc_out_o);
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    start_i     = 1'b0;
    num_terms_i = '0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    test_reset();
    test_back_to_back();
    test_carry_half();
    test_overflow();
    test_zero_terms();
    test_gaps_and_hold();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
